gerador_entradas_fuzzy: RTL
===========================

# gerador_entradas_fuzzy

Front-end stage of the type-2 fuzzy controller. It samples a setpoint and a plant measurement on a strobe and computes error and change-of-error. It scales and saturates both into the 8-bit offset-binary format expected on `Entrada_01`/`Entrada_02`. It then pulses `EN_REGRAS` and holds both inputs stable while the fuzzifier, rule sequencer, inference and type-reduction chain runs.

## Interface
- `SHIFT_E`, 1: arithmetic right shift applied to error before saturation
- `SHIFT_DE`, 0: arithmetic right shift applied to change-of-error before saturation
- `CICLOS_CONTROLE`, 64: cycles inputs are held after `EN_REGRAS` before a new sample is accepted (≥1)

- `clk_0`  in  1  single clock; all logic on rising edge
- `Srst`  in  1  reset, synchronous, active-low
- `amostra`  in  1  sample strobe, sampled each edge
- `referencia`  in  8  setpoint, unsigned
- `medida`  in  8  plant measurement, unsigned
- `Entrada_01`  out  8  error, offset-binary (128 = zero)
- `Entrada_02`  out  8  change-of-error, offset-binary (128 = zero)
- `EN_REGRAS`  out  1  one-cycle start pulse to rule control unit
- `ocupado`  out  1  high in every state except OCIOSO
- `erro_sat`  out  1  last update clipped either channel
- `perda`  out  1  one-cycle pulse: `amostra` seen while busy

## Operation
- FSM states: OCIOSO → CALCULA → SATURA → DISPARA → ESPERA → OCIOSO.
- OCIOSO: on `amostra`=1, latch `referencia` and `medida`, then go to CALCULA.
- CALCULA:
  - e = ref − med, 9-bit signed, range −255..255.
  - de = e − e_prev, 10-bit signed, range −510..510.
  - If the `primeira` flag is set, de = 0.
- SATURA:
  - es = e >>> SHIFT_E and ds = de >>> SHIFT_DE. Shifts are arithmetic and floor toward −∞ (−3>>>1 = −2).
  - Clamp each to [−128, 127], then add 128 and register into `Entrada_01`/`Entrada_02`.
  - `erro_sat` = (es clamped) OR (ds clamped).
  - e_prev ← e (unscaled); `primeira` ← 0.
- DISPARA: `EN_REGRAS`=1 for exactly this one cycle.
- ESPERA: counter runs 0..CICLOS_CONTROLE−1, then the FSM returns to OCIOSO.
- `Entrada_01`/`Entrada_02`/`erro_sat` change only in SATURA; they are stable through DISPARA and ESPERA and until the next SATURA.
- `amostra`=1 in any state other than OCIOSO:
  - The sample is dropped.
  - `perda`=1 on the following cycle.
  - The FSM is unaffected.
- `amostra` held high continuously: a new sample is accepted on every return to OCIOSO.

## Timing
- `amostra` sampled high at edge k in OCIOSO → CALCULA at k+1 → outputs update at edge k+2 → `EN_REGRAS` high from k+2 to k+3.
- ESPERA covers k+3 .. k+3+CICLOS_CONTROLE−1; OCIOSO is reached after edge k+3+CICLOS_CONTROLE.
- Earliest next accepted sample is at that edge. Sample period minimum = CICLOS_CONTROLE+3 cycles.
- `ocupado` is high from after edge k until the return to OCIOSO.
- Reset (`Srst`=0 at an edge) takes effect on that edge, overrides everything, and aborts mid-operation with no `EN_REGRAS`. Reset values:
  - state OCIOSO
  - `Entrada_01`=`Entrada_02`=128
  - `EN_REGRAS`=0, `ocupado`=0, `erro_sat`=0, `perda`=0
  - e_prev=0, `primeira`=1, counter=0
- First sample after reset always yields `Entrada_02`=128.

## Test plan
Defaults: SHIFT_E=1, SHIFT_DE=0, CICLOS_CONTROLE=64.
- Reset, then ref=200, med=100, pulse `amostra` → 2 cycles later `Entrada_01`=178, `Entrada_02`=128, `erro_sat`=0; `EN_REGRAS` one cycle; `ocupado` high 67 cycles.
- Following sample ref=200, med=150 → `Entrada_01`=153, `Entrada_02`=78 (de=−50).
- Reset, then ref=0, med=255 → `Entrada_01`=0 (−128, no clip), `erro_sat`=0. Next ref=255, med=0 → `Entrada_01`=255, `Entrada_02`=255 (de=510 clipped), `erro_sat`=1.
- Negative floor: ref=97, med=100 → e=−3, `Entrada_01`=126.
- `amostra` pulsed 10 cycles after acceptance → `perda` one cycle, no extra `EN_REGRAS`, outputs unchanged; `amostra` tied high → `EN_REGRAS` every 67 cycles.
- `Srst`=0 during ESPERA → next cycle all outputs at reset values; next sample behaves as first (`Entrada_02`=128).

Source files
------------

// File: rtl/gerador_entradas_fuzzy_if.sv
// Handshake and data bundle between the sampling front-end and the fuzzy rule chain.
interface gerador_entradas_fuzzy_if;
  logic       amostra;
  logic [7:0] referencia;
  logic [7:0] medida;
  logic [7:0] Entrada_01;
  logic [7:0] Entrada_02;
  logic       EN_REGRAS;
  logic       ocupado;
  logic       erro_sat;
  logic       perda;

  modport slave (
    input  amostra, referencia, medida,
    output Entrada_01, Entrada_02, EN_REGRAS, ocupado, erro_sat, perda
  );

  modport master (
    output amostra, referencia, medida,
    input  Entrada_01, Entrada_02, EN_REGRAS, ocupado, erro_sat, perda
  );
endinterface

// File: rtl/gerador_entradas_fuzzy.sv
// Fuzzy controller front-end: samples setpoint/measurement, forms error and change-of-error,
// scales/saturates to offset-binary and holds them while the rule chain runs.
module gerador_entradas_fuzzy #(
  parameter int SHIFT_E         = 1,
  parameter int SHIFT_DE        = 0,
  parameter int CICLOS_CONTROLE = 64
) (
  input  logic                     clk_0,
  input  logic                     Srst,
  gerador_entradas_fuzzy_if.slave  bus_if
);

  typedef enum logic [2:0] {OCIOSO, CALCULA, SATURA, DISPARA, ESPERA} estado_t;

  localparam int            CW      = (CICLOS_CONTROLE > 1) ? $clog2(CICLOS_CONTROLE) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(CICLOS_CONTROLE - 1);

  estado_t            estado_q, estado_d;
  logic [7:0]         ref_q, ref_d, med_q, med_d;
  logic signed [8:0]  e_q, e_d, e_prev_q, e_prev_d;
  logic signed [9:0]  de_q, de_d;
  logic               primeira_q, primeira_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         ent1_q, ent1_d, ent2_q, ent2_d;
  logic               sat_q, sat_d, perda_q, perda_d;

  logic               aceita;
  logic signed [9:0]  es, ds;
  logic               es_hi, es_lo, ds_hi, ds_lo;
  logic [7:0]         es_ob, ds_ob;

  // Scaled values and their offset-binary clamp, consumed only in SATURA.
  always_comb begin
    es    = $signed({e_q[8], e_q}) >>> SHIFT_E;
    ds    = de_q >>> SHIFT_DE;
    es_hi = es > 10'sd127;
    es_lo = es < -10'sd128;
    ds_hi = ds > 10'sd127;
    ds_lo = ds < -10'sd128;
    es_ob = es_hi ? 8'hFF : es_lo ? 8'h00 : (es[7:0] ^ 8'h80);
    ds_ob = ds_hi ? 8'hFF : ds_lo ? 8'h00 : (ds[7:0] ^ 8'h80);
  end

  always_comb begin
    estado_d   = estado_q;
    ref_d      = ref_q;
    med_d      = med_q;
    e_d        = e_q;
    de_d       = de_q;
    e_prev_d   = e_prev_q;
    primeira_d = primeira_q;
    cnt_d      = cnt_q;
    ent1_d     = ent1_q;
    ent2_d     = ent2_q;
    sat_d      = sat_q;
    // The edge that closes ESPERA is also the return to OCIOSO, so a strobe there
    // is taken, giving a back-to-back period of CICLOS_CONTROLE+3.
    aceita  = bus_if.amostra &&
              (estado_q == OCIOSO || (estado_q == ESPERA && cnt_q == CNT_FIM));
    perda_d = bus_if.amostra && (estado_q != OCIOSO) && !aceita;

    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          ref_d    = bus_if.referencia;
          med_d    = bus_if.medida;
          estado_d = CALCULA;
        end
      end
      CALCULA: begin
        e_d      = {1'b0, ref_q} - {1'b0, med_q};
        de_d     = primeira_q ? 10'sd0 : ({e_d[8], e_d} - {e_prev_q[8], e_prev_q});
        estado_d = SATURA;
      end
      SATURA: begin
        ent1_d     = es_ob;
        ent2_d     = ds_ob;
        sat_d      = es_hi | es_lo | ds_hi | ds_lo;
        e_prev_d   = e_q;
        primeira_d = 1'b0;
        estado_d   = DISPARA;
      end
      DISPARA: begin
        cnt_d    = '0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (cnt_q == CNT_FIM) begin
          if (aceita) begin
            ref_d    = bus_if.referencia;
            med_d    = bus_if.medida;
            estado_d = CALCULA;
          end else begin
            estado_d = OCIOSO;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (!Srst) begin
      estado_q   <= OCIOSO;
      ref_q      <= '0;
      med_q      <= '0;
      e_q        <= '0;
      de_q       <= '0;
      e_prev_q   <= '0;
      primeira_q <= 1'b1;
      cnt_q      <= '0;
      ent1_q     <= 8'd128;
      ent2_q     <= 8'd128;
      sat_q      <= 1'b0;
      perda_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ref_q      <= ref_d;
      med_q      <= med_d;
      e_q        <= e_d;
      de_q       <= de_d;
      e_prev_q   <= e_prev_d;
      primeira_q <= primeira_d;
      cnt_q      <= cnt_d;
      ent1_q     <= ent1_d;
      ent2_q     <= ent2_d;
      sat_q      <= sat_d;
      perda_q    <= perda_d;
    end
  end

  assign bus_if.Entrada_01 = ent1_q;
  assign bus_if.Entrada_02 = ent2_q;
  assign bus_if.EN_REGRAS  = (estado_q == DISPARA);
  assign bus_if.ocupado    = (estado_q != OCIOSO);
  assign bus_if.erro_sat   = sat_q;
  assign bus_if.perda      = perda_q;

endmodule
